// File: rtl/ofm_pack_writer_if.sv
// Byte-in / word-out bus of the OFM pack writer.
// Slave side is the writer; master side is the controller, MAC stage and memory.
interface ofm_pack_writer_if #(
  parameter int ADDR_W = 8
);
  logic              frame_start;
  logic              wrofm;
  logic [7:0]        macout;
  logic              frame_last;
  logic              in_ready;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  logic [ADDR_W:0]   word_count;
  logic              done;

  modport master (
    output frame_start, wrofm, macout,
    output frame_last, mem_ready,
    input  in_ready, mem_wen, mem_addr,
    input  mem_wdata, word_count, done
  );

  modport slave (
    input  frame_start, wrofm, macout,
    input  frame_last, mem_ready,
    output in_ready, mem_wen, mem_addr,
    output mem_wdata, word_count, done
  );
endinterface

// File: rtl/ofm_pack_writer.sv
// Packs MAC result bytes into 32-bit words and writes them out via a word FIFO.
// Define OFM_FLUSH_EN to also write a zero-padded trailing partial word.
module ofm_pack_writer #(
  parameter int ADDR_W     = 8,
  parameter int BASE_ADDR  = 0,
  parameter int FIFO_DEPTH = 4
) (
  input logic              clk,
  input logic              rst,
  ofm_pack_writer_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {
    IDLE,
    PACK,
    DRAIN,
    DONE
  } state_t;

  state_t            state_q;
  logic [1:0]        byte_cnt_q;
  logic [31:0]       word_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   wcnt_q;
  logic              done_q;

  logic [31:0]       fifo_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_q;
  logic [PW-1:0]     rd_q;
  logic [CW-1:0]     cnt_q;

  logic        empty;
  logic        full;
  logic        acc;
  logic        word_push;
  logic        flush_push;
  logic        push;
  logic        pop;
  logic        pend;
  logic [31:0] lane_word;
  logic [31:0] push_data;

`ifdef OFM_FLUSH_EN
  logic pend_q;
  assign pend       = pend_q;
  assign flush_push = (state_q == DRAIN) && pend_q && !full;
`else
  assign pend       = 1'b0;
  assign flush_push = 1'b0;
`endif

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == CW'(FIFO_DEPTH));
  assign acc       = bus.wrofm && bus.in_ready;
  assign word_push = acc && (byte_cnt_q == 2'd3);
  assign push      = word_push || flush_push;
  assign pop       = !empty && bus.mem_ready;
  assign push_data = word_push ? lane_word : word_q;

  always_comb begin
    lane_word = word_q;
    lane_word[{byte_cnt_q, 3'b000} +: 8] = bus.macout;
  end

  assign bus.in_ready   = (state_q == PACK) && !full;
  assign bus.mem_wen    = !empty;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = empty ? '0 : fifo_q[rd_q];
  assign bus.word_count = wcnt_q;
  assign bus.done       = done_q;

  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      word_q     <= '0;
      addr_q     <= BASE;
      wcnt_q     <= '0;
      done_q     <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
`ifdef OFM_FLUSH_EN
      pend_q     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      cnt_q  <= cnt_q + CW'(push) - CW'(pop);
      if (push) begin
        wr_q <= wr_q + 1'b1;
      end
      if (pop) begin
        rd_q   <= rd_q + 1'b1;
        addr_q <= addr_q + 1'b1;
        wcnt_q <= wcnt_q + 1'b1;
      end
      unique case (state_q)
        IDLE, DONE: begin
          if (bus.frame_start) begin
            state_q    <= PACK;
            byte_cnt_q <= '0;
            word_q     <= '0;
            addr_q     <= BASE;
            wcnt_q     <= '0;
`ifdef OFM_FLUSH_EN
            pend_q     <= 1'b0;
`endif
          end else if (state_q == DONE) begin
            state_q <= IDLE;
          end
        end
        PACK: begin
          if (acc) begin
            byte_cnt_q <= byte_cnt_q + 1'b1;
            word_q     <= word_push ? '0 : lane_word;
            if (bus.frame_last) begin
              state_q    <= DRAIN;
              byte_cnt_q <= '0;
`ifdef OFM_FLUSH_EN
              pend_q     <= !word_push;
`else
              word_q     <= '0;
`endif
            end
          end
        end
        DRAIN: begin
          if (flush_push) begin
`ifdef OFM_FLUSH_EN
            pend_q <= 1'b0;
`endif
            word_q <= '0;
          end else if (empty && !pend) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ofm_pack_writer.sv
// Randomised and directed bench for ofm_pack_writer.
// Reference model tracks bytes, pending words and counts with queues.
module tb_ofm_pack_writer;
  localparam int AW    = 2;
  localparam int BASE  = 2;
  localparam int DEPTH = 4;

  localparam int S_IDLE  = 0;
  localparam int S_PACK  = 1;
  localparam int S_DRAIN = 2;
  localparam int S_DONE  = 3;

  logic clk = 1'b0;
  logic rst;

  ofm_pack_writer_if #(.ADDR_W(AW)) bus ();

  ofm_pack_writer #(
    .ADDR_W(AW),
    .BASE_ADDR(BASE),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int          mst;
  logic [31:0] fq [$];
  logic [7:0]  bq [$];
  bit          pend;
  int          wc;
  bit          acc_f;
  bit          done_f;
  int          stall_idx;

  logic [31:0] log_d [$];
  int          log_a [$];
  logic [7:0]  stim [$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pack_bytes();
    logic [31:0] w;
    w = '0;
    foreach (bq[i]) w[8*i +: 8] = bq[i];
    return w;
  endfunction

  task automatic model_reset();
    mst  = S_IDLE;
    fq.delete();
    bq.delete();
    pend = 0;
    wc   = 0;
  endtask

  // Observe the cycle just before the rising edge, then advance the model.
  task automatic tick();
    bit inr;
    bit pop;
    int presize;
    #1;
    inr    = (mst == S_PACK) && (fq.size() < DEPTH);
    pop    = (fq.size() != 0) && bus.mem_ready;
    acc_f  = bus.wrofm && inr;
    done_f = (mst == S_DONE);
    if (!rst) begin
      chk("in_ready", bus.in_ready, inr);
      chk("mem_wen", bus.mem_wen, fq.size() != 0);
      chk("mem_addr", bus.mem_addr, (BASE + wc) % (1 << AW));
      chk("word_count", bus.word_count, wc);
      chk("done", bus.done, done_f);
      if (fq.size() != 0) chk("mem_wdata", bus.mem_wdata, fq[0]);
    end
    if (rst) begin
      model_reset();
    end else begin
      presize = fq.size();
      if (pop) begin
        log_d.push_back(fq[0]);
        log_a.push_back((BASE + wc) % (1 << AW));
        void'(fq.pop_front());
        wc++;
      end
      if (mst == S_IDLE || mst == S_DONE) begin
        if (bus.frame_start) begin
          mst = S_PACK;
          wc  = 0;
          bq.delete();
          pend = 0;
        end else if (mst == S_DONE) begin
          mst = S_IDLE;
        end
      end else if (mst == S_PACK) begin
        if (acc_f) begin
          bq.push_back(bus.macout);
          if (bq.size() == 4) begin
            fq.push_back(pack_bytes());
            bq.delete();
          end
          if (bus.frame_last) begin
            mst = S_DRAIN;
`ifdef OFM_FLUSH_EN
            pend = (bq.size() != 0);
`else
            bq.delete();
`endif
          end
        end
      end else begin
        if (pend) begin
          if (presize < DEPTH) begin
            fq.push_back(pack_bytes());
            bq.delete();
            pend = 0;
          end
        end else if (presize == 0) begin
          mst = S_DONE;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic run_frame(input int n, input int rdy_pct,
                           input int gap_pct, input int fs_pct,
                           input int stall);
    int idx;
    int guard;
    bit seen;
    idx  = 0;
    guard = 0;
    seen = 0;
    bus.frame_start = 1'b1;
    bus.wrofm       = 1'b0;
    bus.mem_ready   = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    while (!seen && guard < 2000) begin
      if (guard < stall) bus.mem_ready = 1'b0;
      else bus.mem_ready = ($urandom_range(99) < rdy_pct);
      if (idx < n) begin
        bus.wrofm       = ($urandom_range(99) >= gap_pct);
        bus.macout      = stim[idx];
        bus.frame_last  = (idx == n - 1);
        bus.frame_start = ($urandom_range(99) < fs_pct);
      end else begin
        bus.wrofm       = 1'b1;
        bus.macout      = 8'($urandom);
        bus.frame_last  = 1'($urandom);
        bus.frame_start = 1'b0;
      end
      tick();
      if (acc_f) idx++;
      if (done_f) seen = 1;
      guard++;
      if (guard == stall) stall_idx = idx;
    end
    checks++;
    assert (seen) else begin
      errors++;
      $error("FAIL frame_timeout: got=no_done want=done");
    end
    bus.wrofm       = 1'b0;
    bus.frame_start = 1'b0;
    bus.frame_last  = 1'b0;
  endtask

  task automatic seq_stim(input int n, input logic [7:0] first);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(first + 8'(i));
  endtask

  initial begin
    int n;
    int guard;
    model_reset();
    rst             = 1'b1;
    bus.frame_start = 1'b0;
    bus.wrofm       = 1'b0;
    bus.macout      = '0;
    bus.frame_last  = 1'b0;
    bus.mem_ready   = 1'b0;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_wdata", bus.mem_wdata, 32'h0);
    chk("rst_addr", bus.mem_addr, BASE);
    tick();
    tick();

    // basic packing
    log_d.delete(); log_a.delete();
    seq_stim(8, 8'h01);
    run_frame(8, 100, 0, 0, 0);
    chk("basic_nwords", log_d.size(), 2);
    if (log_d.size() == 2) begin
      chk("basic_w0", log_d[0], 32'h04030201);
      chk("basic_w1", log_d[1], 32'h08070605);
      chk("basic_a0", log_a[0], 2);
      chk("basic_a1", log_a[1], 3);
    end
    chk("basic_wc", bus.word_count, 2);
    tick();

    // backpressure
    log_d.delete(); log_a.delete();
    seq_stim(20, 8'h01);
    run_frame(20, 100, 0, 0, 30);
    chk("bp_accepted", stall_idx, 16);
    chk("bp_nwords", log_d.size(), 5);
    if (log_d.size() == 5) begin
      chk("bp_w0", log_d[0], 32'h04030201);
      chk("bp_w4", log_d[4], 32'h14131211);
      chk("bp_a4", log_a[4], 2);
    end
    chk("bp_wc", bus.word_count, 5);

    // partial frame
    log_d.delete(); log_a.delete();
    seq_stim(6, 8'h01);
    run_frame(6, 100, 0, 0, 0);
`ifdef OFM_FLUSH_EN
    chk("part_nwords", log_d.size(), 2);
    if (log_d.size() == 2) chk("part_w1", log_d[1], 32'h00000605);
    chk("part_wc", bus.word_count, 2);
`else
    chk("part_nwords", log_d.size(), 1);
    chk("part_wc", bus.word_count, 1);
`endif

    // address wrap
    log_d.delete(); log_a.delete();
    seq_stim(12, 8'h30);
    run_frame(12, 100, 0, 0, 0);
    chk("wrap_nwords", log_a.size(), 3);
    if (log_a.size() == 3) begin
      chk("wrap_a0", log_a[0], 2);
      chk("wrap_a1", log_a[1], 3);
      chk("wrap_a2", log_a[2], 0);
    end

    // reset mid-frame
    bus.frame_start = 1'b1;
    bus.mem_ready   = 1'b0;
    tick();
    bus.frame_start = 1'b0;
    n = 0;
    guard = 0;
    while (n < 5 && guard < 50) begin
      bus.wrofm  = 1'b1;
      bus.macout = 8'h50 + 8'(n);
      tick();
      if (acc_f) n++;
      guard++;
    end
    bus.wrofm = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    log_d.delete(); log_a.delete();
    tick();
    seq_stim(4, 8'hAA);
    run_frame(4, 100, 0, 0, 0);
    chk("rst_nwords", log_d.size(), 1);
    if (log_d.size() == 1) begin
      chk("rst_w0", log_d[0], 32'hADACABAA);
      chk("rst_a0", log_a[0], BASE);
    end

    // frame_start during PACK is ignored
    log_d.delete(); log_a.delete();
    seq_stim(8, 8'h11);
    run_frame(8, 100, 30, 50, 0);
    chk("ign_nwords", log_d.size(), 2);
    chk("ign_wc", bus.word_count, 2);

    // random frames
    for (int f = 0; f < 12; f++) begin
      n = $urandom_range(28, 1);
      stim.delete();
      for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
      run_frame(n, $urandom_range(100, 30), $urandom_range(50, 0), 10, 0);
      repeat ($urandom_range(3, 0)) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
